// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive path between the host and the CPU.
// The line is brought into the clk domain through a two-flop synchronizer.
// A start/data/stop FSM samples each bit in the middle of its bit time.
// LSB-first bytes are collected in a shift register. Each completed byte is
// handed to the CPU through a one-entry ready/valid holding register.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  // Clocks per bit, and the mid-bit sample point inside each bit time.
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             rx_meta;
  logic             rx_s;

  // Two-stage synchronizer for the asynchronous serial line.
  // NOTE: both stages reset to 1 (line idle). A reset value of 0 would look
  // like a start bit immediately after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let rx_s take the old rx_meta value.
      // This builds two flops. Blocking assignments would collapse the chain
      // to a single stage.
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with its counters, plus the holding register and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;

      // NOTE: this clear comes before the STOP-state load below. When a byte
      // is accepted and a new byte loads in the same cycle, the later
      // assignment wins, so valid stays high and holds the new byte.
      if (data_out_valid && data_out_ready)
        data_out_valid <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rx_s)
            state <= START;
        end

        START: begin
          if (clk_cnt == SAMPLE_LAST && rx_s) begin
            // The line went high again before mid-bit: treat it as a glitch.
            state   <= IDLE;
            clk_cnt <= '0;
          end else if (clk_cnt == SYMBOL_LAST) begin
            state   <= DATA;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == SAMPLE_LAST)
            shift_reg <= {rx_s, shift_reg[7:1]};
          if (clk_cnt == SYMBOL_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7)
              state <= STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          // Decide at mid stop bit and return to IDLE right away, so a
          // following frame sent with a minimal stop bit is not missed.
          if (clk_cnt == SAMPLE_LAST) begin
            state   <= IDLE;
            clk_cnt <= '0;
            if (!rx_s) begin
              framing_error <= 1'b1;
            end else if (!data_out_valid || data_out_ready) begin
              data_out       <= shift_reg;
              data_out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the 8N1 serial link between the host and the CPU.
- Samples the serial line (from the top-level RX IOB register) at mid-bit. Assembles LSB-first bytes.
- Presents each byte through a one-entry ready/valid holding register to the CPU memory-mapped UART logic.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
CLOCK_FREQ, 125_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s
(derived, not overridable) SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer-truncated clocks per bit; SAMPLE_TIME = SYMBOL_EDGE_TIME / 2

Ports:
clk  input  1  single clock; all state on posedge
rst  input  1  asynchronous, active-high reset
serial_in  input  1  serial line, idle high; asynchronous to clk
data_out  output  8  received byte
data_out_valid  output  1  holding register full
data_out_ready  input  1  consumer accepts byte when high with valid
framing_error  output  1  1-cycle pulse: stop bit sampled low
overrun  output  1  1-cycle pulse: completed byte dropped, holding register full

Behaviour:
- Reset (async, rst=1): 2-flop input synchronizer = 1, state IDLE, counters 0, shift reg 0. Outputs: data_out=0, data_out_valid=0, framing_error=0, overrun=0. Reset mid-frame abandons the frame. After reset release, the receiver resyncs on the next falling edge seen in IDLE.
- Input: serial_in passes through a 2-stage synchronizer. rx_s = second stage. All decisions use rx_s, giving 2 cycles of latency from pin.
- Counter clk_cnt: 0..SYMBOL_EDGE_TIME-1, zeroed on every state entry, wraps at SYMBOL_EDGE_TIME-1. bit_cnt: 0..7.
- IDLE: rx_s==0 -> START, clk_cnt=0.
- START:
  - clk_cnt==SAMPLE_TIME-1 and rx_s==1 -> false start, back to IDLE. No pulse.
  - clk_cnt==SYMBOL_EDGE_TIME-1 -> DATA, bit_cnt=0.
- DATA:
  - clk_cnt==SAMPLE_TIME-1: shift rx_s into bit 7 of the shift reg (right shift), so LSB arrives first.
  - clk_cnt==SYMBOL_EDGE_TIME-1: bit_cnt==7 -> STOP, else bit_cnt+1.
- STOP: at clk_cnt==SAMPLE_TIME-1, sample rx_s, go to IDLE the next cycle. Do not wait for the full stop bit, so back-to-back frames with a minimal stop bit are caught.
  - rx_s==1, holding register free or freed this cycle: load data_out, data_out_valid=1 next cycle.
  - rx_s==1, holding register full and not accepted this cycle: byte dropped, old data_out retained, overrun=1 for one cycle.
  - rx_s==0: byte discarded, framing_error=1 for one cycle, holding register untouched.
- Handshake:
  - data_out_valid && data_out_ready at posedge -> valid clears next cycle, unless a new byte loads in the same cycle, in which case valid stays 1 with the new byte.
  - data_out is stable while valid=1 and not accepted.
  - data_out_ready with valid=0 has no effect.
- Latency: pin falling edge to data_out_valid = 2 + 9*SYMBOL_EDGE_TIME + SAMPLE_TIME + 1 clocks, for perfectly aligned edges.
- No parity. serial_in glitches shorter than SAMPLE_TIME in IDLE are rejected by the false-start check.

Test Plan:
(All with CLOCK_FREQ=1000, BAUD_RATE=100: SYMBOL_EDGE_TIME=10, SAMPLE_TIME=5.)
1. Drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop), data_out_ready=0 -> data_out_valid rises exactly 98 clocks after the start edge with data_out=8'hA5, and stays until ready; assert ready 1 cycle -> valid=0 next cycle.
2. Low glitch of 3 clocks on idle line, then 0x3C frame -> glitch ignored, no pulses, data_out=8'h3C.
3. Frame 0x5A with stop bit driven 0 -> framing_error pulses 1 cycle, data_out_valid stays 0.
4. Send 0x11 then 0x22 back-to-back with ready held 0 -> data_out=8'h11 held, overrun pulses once at the second stop sample. Then ready=1 -> valid drops, and 0x22 is not delivered.
5. ready held 1 continuously, 0x01, 0x02, 0x03 back-to-back with 1-bit stop -> three single-cycle valid pulses, bytes in order, no overrun.
6. Assert rst during bit 4 of 0xFF -> all outputs 0 immediately (async). After release, a clean 0x80 frame is received correctly.
